pc_predict: RTL and testbench
=============================

# pc_predict

Parametrised program-counter unit that succeeds the plain PC-plus-branch block in the fetch stage. It holds the fetch PC and supports pipeline stall and execute-stage redirect. It also predicts the next PC through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and trains that BTB from resolved control-flow instructions. It sits between the execute stage, which supplies redirect and update, and instruction memory, which is addressed by `PCout`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, PC and target width.
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- `BTB_ENTRIES`, 16, number of BTB entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hold PC this cycle.
- `redirect`  in  1  execute-stage correction; overrides everything.
- `redirect_pc`  in  DATA_WIDTH  corrected next PC.
- `upd_valid`  in  1  resolved branch/jump, trains the BTB.
- `upd_pc`  in  DATA_WIDTH  PC of the resolved instruction.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  DATA_WIDTH  actual target.
- `PCout`  out  DATA_WIDTH  current fetch PC.
- `pred_taken`  out  1  prediction for `PCout`.
- `pred_target`  out  DATA_WIDTH  predicted target for `PCout`; valid when `pred_taken`.
- `misaligned`  out  1  one-cycle flag: the previous redirect had nonzero bits [1:0].

## Operation
- **Index and tag.** IDX_W = log2(BTB_ENTRIES). Index = pc[IDX_W+1:2]; tag = pc[DATA_WIDTH-1:IDX_W+2].
- **Entry contents.** Each entry holds valid, tag, target and ctr[1:0]. Counter states are SNT=00, WNT=01, WT=10, ST=11.
- **Lookup.** Combinational on `PCout`. hit = valid && tag match. `pred_taken` = hit && ctr[1]. `pred_target` = entry target, or 0 when there is no hit.
- **Next-PC priority** (highest first):
  1. `redirect`: PC ← {redirect_pc[DATA_WIDTH-1:2], 2'b00}.
  2. `stall`: PC holds.
  3. `pred_taken`: PC ← `pred_target`.
  4. Otherwise: PC ← PCout + 4, wrapping modulo 2^DATA_WIDTH; 0xFFFF_FFFC → 0x0000_0000.
- **Redirect with stall.** Redirect applies even when `stall`=1.
- **misaligned.** Registered. Set to 1 on the edge where `redirect`=1 and redirect_pc[1:0]≠0; cleared on every other edge.
- **BTB update on upd_valid, hit on upd_pc:**
  - ctr saturating-increments if `upd_taken`, otherwise saturating-decrements.
  - Target ← `upd_target` if `upd_taken`.
- **BTB update on upd_valid, miss on upd_pc:**
  - If `upd_taken`: allocate (overwrite the index). Set valid=1, tag, target, ctr=WT.
  - If not taken: no change.
- **Independence.** Update is independent of `stall` and `redirect`; both may fire in the same cycle.
- **Reset** (rst=0, asynchronous):
  - `PCout` = RESET_VECTOR, `misaligned` = 0.
  - All valid bits = 0, so `pred_taken` = 0 and `pred_target` = 0.
  - Target and ctr fields need no reset.
  - Reset asserted mid-operation discards any in-flight update.

## Timing
- **Fetch.** Zero-latency prediction: `pred_taken`/`pred_target` reflect the current `PCout` in the same cycle. `PCout` changes only on a rising edge.
- **Redirect.** Latency 1: redirect sampled at edge N, so `PCout` = new value after edge N.
- **Update visibility.** An update written at edge N affects lookups from cycle N+1 onward.
- **Same-cycle conflict.** Lookup and update to the same index in one cycle: lookup sees the old entry.
- **After reset.** First fetch after rst deasserts is RESET_VECTOR; the next edge advances to RESET_VECTOR+4 unless stalled.

## Structure
- **Package `pc_pkg`:**
  - Counter constants SNT/WNT/WT/ST and the `ctr_t` typedef.
  - Struct `btb_entry_t` {valid, tag, target, ctr}, parametrised via localparams derived from DATA_WIDTH and BTB_ENTRIES.
  - Function for saturating counter update.
- **Sub-module `btb`:** storage array, combinational read port on the lookup PC, synchronous write port for training, asynchronous clear of valid bits.
- **`pc_predict` top:** PC register, next-PC priority mux, `misaligned` flag.

## Test plan
- **Reset and sequential fetch.** Hold rst=0, then release; RESET_VECTOR=0x100, no stall/redirect → `PCout` 0x100, 0x104, 0x108 on successive edges; `pred_taken`=0.
- **Allocation and prediction.** Update with upd_pc=0x108, taken, target=0x200 → next time `PCout`=0x108, `pred_taken`=1, `pred_target`=0x200, and the following PC is 0x200.
- **Counter saturation.** Starting from WT, two not-taken updates at 0x108 → counter reaches WNT then SNT, `pred_taken`=0, PC goes 0x108→0x10C. A third not-taken update keeps SNT. Two taken updates return the counter to WT.
- **Priority.** stall=1 and redirect=1 with redirect_pc=0x400 → `PCout`=0x400 next cycle. With stall=1 alone, `PCout` holds for 3 cycles, then resumes +4.
- **Misaligned redirect and wrap.**
  - redirect_pc=0x402 → `PCout`=0x400, `misaligned`=1 for exactly one cycle.
  - PC=0xFFFF_FFFC with no hit → next PC 0x0000_0000.
- **Tag alias and async reset.**
  - With BTB_ENTRIES=16, train 0x108 taken, then train 0x148 (same index, different tag) taken → 0x108 now misses.
  - Assert rst mid-stream, between edges → `PCout` becomes RESET_VECTOR immediately and all predictions clear.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared BTB counter encoding, default entry layout and counter training helper.
package pc_pkg;
    typedef logic [1:0] ctr_t;
    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    localparam int BTB_DW    = 32;
    localparam int BTB_DEPTH = 16;
    localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
    localparam int BTB_TAG_W = BTB_DW - BTB_IDX_W - 2;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_DW-1:0]    target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        return taken ? ((c == ST) ? ST : ctr_t'(c + 2'd1))
                     : ((c == SNT) ? SNT : ctr_t'(c - 2'd1));
    endfunction
endpackage

// File: rtl/btb.sv
// btb: direct-mapped branch target buffer, combinational lookup, synchronous training.
module btb
    import pc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] lookup_pc,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [DATA_WIDTH-1:0] target;
        ctr_t                  ctr;
    } entry_t;

    entry_t           mem [BTB_ENTRIES];
    entry_t           rd, wr;
    logic [IDX_W-1:0] ridx, widx;
    logic             rhit, whit;

    assign ridx        = lookup_pc[IDX_W+1:2];
    assign widx        = upd_pc[IDX_W+1:2];
    assign rd          = mem[ridx];
    assign wr          = mem[widx];
    assign rhit        = rd.valid && rd.tag == lookup_pc[DATA_WIDTH-1:IDX_W+2];
    assign whit        = wr.valid && wr.tag == upd_pc[DATA_WIDTH-1:IDX_W+2];
    assign pred_taken  = rhit && rd.ctr[1];
    assign pred_target = rhit ? rd.target : '0;

    // Only valid bits are cleared; stale target/ctr are unreachable until reallocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) mem[i].valid <= 1'b0;
        end else if (upd_valid && whit) begin
            mem[widx].ctr <= ctr_update(wr.ctr, upd_taken);
            if (upd_taken) mem[widx].target <= upd_target;
        end else if (upd_valid && upd_taken) begin
            mem[widx] <= '{valid: 1'b1, tag: upd_pc[DATA_WIDTH-1:IDX_W+2], target: upd_target, ctr: WT};
        end
    end
endmodule

// File: rtl/pc_predict.sv
// pc_predict: fetch PC register with redirect/stall priority and BTB-driven next-PC prediction.
module pc_predict
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    BTB_ENTRIES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    output logic [DATA_WIDTH-1:0] PCout,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    output logic                  misaligned
);
    logic [DATA_WIDTH-1:0] next_pc;

    btb #(.DATA_WIDTH(DATA_WIDTH), .BTB_ENTRIES(BTB_ENTRIES)) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (PCout),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    assign next_pc = redirect   ? {redirect_pc[DATA_WIDTH-1:2], 2'b00} :
                     stall      ? PCout :
                     pred_taken ? pred_target :
                                  PCout + DATA_WIDTH'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PCout      <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else begin
            PCout      <= next_pc;
            misaligned <= redirect && |redirect_pc[1:0];
        end
    end
endmodule

// File: tb/tb_pc_predict.sv
// tb_pc_predict: directed test-plan scenarios plus random traffic against a table-based BTB model.
module tb_pc_predict;
    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
    logic [31:0] redirect_pc = '0, upd_pc = '0, upd_target = '0;
    logic [31:0] PCout, pred_target;
    logic        pred_taken, misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: per-slot record of the word address that owns it, its target and a 0..3 confidence.
    bit          m_valid [16];
    bit   [29:0] m_owner [16];
    bit   [31:0] m_tgt   [16];
    int          m_conf  [16];
    bit   [31:0] m_pc;
    bit          m_mis;

    pc_predict #(.DATA_WIDTH(32), .RESET_VECTOR(RV), .BTB_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .PCout(PCout), .pred_taken(pred_taken), .pred_target(pred_target), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slot(input bit [31:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic bit owns(input bit [31:0] a);
        return m_valid[slot(a)] && m_owner[slot(a)] == a[31:2];
    endfunction

    function automatic bit m_ptaken();
        return owns(m_pc) && m_conf[slot(m_pc)] >= 2;
    endfunction

    function automatic bit [31:0] m_ptarget();
        return owns(m_pc) ? m_tgt[slot(m_pc)] : 32'h0;
    endfunction

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_pc  = RV;
        m_mis = 1'b0;
    endtask

    task automatic compare();
        check("pc", PCout, m_pc);
        check("pred_taken", {31'b0, pred_taken}, {31'b0, m_ptaken()});
        check("pred_target", pred_target, m_ptarget());
        check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    endtask

    task automatic drive(input bit r, input bit [31:0] rpc, input bit s,
                         input bit uv, input bit [31:0] upc, input bit ut, input bit [31:0] utg);
        redirect = r; redirect_pc = rpc; stall = s;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    endtask

    task automatic cycle();
        bit [31:0] npc;
        int        j;
        npc = redirect ? (redirect_pc & 32'hFFFF_FFFC) : stall ? m_pc :
              m_ptaken() ? m_ptarget() : m_pc + 32'd4;
        j = slot(upd_pc);
        if (upd_valid) begin
            if (owns(upd_pc)) begin
                m_conf[j] = upd_taken ? ((m_conf[j] == 3) ? 3 : m_conf[j] + 1)
                                      : ((m_conf[j] == 0) ? 0 : m_conf[j] - 1);
                if (upd_taken) m_tgt[j] = upd_target;
            end else if (upd_taken) begin
                m_valid[j] = 1'b1; m_owner[j] = upd_pc[31:2]; m_tgt[j] = upd_target; m_conf[j] = 2;
            end
        end
        m_mis = redirect && (redirect_pc[1:0] != 2'b00);
        @(posedge clk);
        m_pc = npc;
        @(negedge clk);
        compare();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        compare();
        rst = 1'b1;
        check("reset_pc", PCout, 32'h100);
        cycle(); check("seq_104", PCout, 32'h104);
        drive(0, 0, 0, 1, 32'h108, 1, 32'h200);
        cycle(); check("alloc_pc", PCout, 32'h108);
        check("alloc_taken", {31'b0, pred_taken}, 32'd1);
        check("alloc_tgt", pred_target, 32'h200);
        cycle(); check("follow_tgt", PCout, 32'h200);
        drive(1, 32'h108, 0, 1, 32'h108, 0, 0);
        cycle(); check("wnt_taken", {31'b0, pred_taken}, 32'd0);
        drive(0, 0, 0, 1, 32'h108, 0, 0);
        cycle(); check("snt_fallthru", PCout, 32'h10C);
        drive(1, 32'h108, 0, 1, 32'h108, 0, 0);
        cycle(); check("snt_sat", {31'b0, pred_taken}, 32'd0);
        drive(1, 32'h108, 0, 1, 32'h108, 1, 32'h200);
        cycle(); check("wnt_again", {31'b0, pred_taken}, 32'd0);
        drive(1, 32'h108, 0, 1, 32'h108, 1, 32'h200);
        cycle(); check("wt_again", {31'b0, pred_taken}, 32'd1);
        drive(1, 32'h400, 1, 0, 0, 0, 0);
        cycle(); check("redir_over_stall", PCout, 32'h400);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 0, 0, 0);
            cycle(); check("stall_hold", PCout, 32'h400);
        end
        cycle(); check("stall_resume", PCout, 32'h404);
        drive(1, 32'h402, 0, 0, 0, 0, 0);
        cycle(); check("mis_pc", PCout, 32'h400);
        check("mis_set", {31'b0, misaligned}, 32'd1);
        cycle(); check("mis_clear", {31'b0, misaligned}, 32'd0);
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        cycle(); check("top_pc", PCout, 32'hFFFF_FFFC);
        cycle(); check("wrap", PCout, 32'h0);
        drive(0, 0, 0, 1, 32'h148, 1, 32'h300);
        cycle();
        drive(1, 32'h108, 0, 0, 0, 0, 0);
        cycle(); check("alias_miss", {31'b0, pred_taken}, 32'd0);
        drive(1, 32'h148, 0, 0, 0, 0, 0);
        cycle(); check("alias_hit_tgt", pred_target, 32'h300);
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                #2 rst = 1'b0;
                #1 model_reset();
                check("async_pc", PCout, RV);
                check("async_taken", {31'b0, pred_taken}, 32'd0);
                compare();
                @(negedge clk);
                rst = 1'b1;
                compare();
            end
            drive($urandom_range(0, 9) == 0,
                  ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                               : 32'h100 + $urandom_range(0, 255),
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1,
                  32'h100 + 32'($urandom_range(0, 63)) * 4,
                  $urandom_range(0, 2) != 0,
                  32'h100 + 32'($urandom_range(0, 63)) * 4);
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
